// File: rtl/router_xbar_out_port.sv
// -----------------------------------------------------------------------------
// router_xbar_out_port
//
// One output-port slice of the mesh router crossbar. It picks one of NUM_IN
// input channels by round-robin arbitration. A multi-flit packet keeps the
// port (wormhole lock) from its header flit to its tail flit. The chosen flit
// is placed in a single registered output stage with a valid/ready handshake.
//
// Parameters:
//   DATA_WIDTH  flit width in bits
//   NUM_IN      number of requesting input channels (2..8)
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_in     per-input request: input i presents a flit for this port
//   tail_in    per-input tail marker of the presented flit
//   data_in    concatenated flits, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ack_out    combinational one-hot pop strobe back to the input FIFOs
//   dataout    registered output flit
//   validout   registered: dataout holds a valid flit
//   ready_in   downstream accepts dataout this cycle
//   grant_out  one-hot current owner / arbitration winner, zero when idle
//   locked     a packet currently owns the port
// -----------------------------------------------------------------------------
module router_xbar_out_port #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN-1:0]            req_in,
    input  logic [NUM_IN-1:0]            tail_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0] data_in,
    output logic [NUM_IN-1:0]            ack_out,
    output logic [DATA_WIDTH-1:0]        dataout,
    output logic                         validout,
    input  logic                         ready_in,
    output logic [NUM_IN-1:0]            grant_out,
    output logic                         locked
);

    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    // One extra bit so that last + k (at most 2*NUM_IN-1) never overflows.
    localparam int SUM_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_IN - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] owner_r;
    logic [IDX_W-1:0] owner_nxt_s;
    logic [IDX_W-1:0] last_r;
    logic [IDX_W-1:0] last_nxt_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] load_idx_s;
    logic [SUM_W-1:0] scan_sum_s;
    logic             scan_hit_s;
    logic             any_req_s;
    logic             can_load_s;
    logic             load_s;

    // The output register can take a new flit when empty or being drained.
    assign can_load_s = ~validout | ready_in;

    assign locked = (state_r == ST_LOCKED);

    // Round-robin scan: first requester after last_r, wrapping NUM_IN-1 -> 0.
    always_comb begin
        winner_s   = '0;
        any_req_s  = 1'b0;
        scan_sum_s = '0;
        scan_hit_s = 1'b0;
        for (int k = 1; k <= NUM_IN; k++) begin
            scan_sum_s = {1'b0, last_r} + SUM_W'(k);
            scan_sum_s = (scan_sum_s >= SUM_W'(NUM_IN)) ? (scan_sum_s - SUM_W'(NUM_IN)) : scan_sum_s;
            scan_hit_s = ~any_req_s & req_in[scan_sum_s[IDX_W-1:0]];
            winner_s   = scan_hit_s ? scan_sum_s[IDX_W-1:0] : winner_s;
            any_req_s  = any_req_s | scan_hit_s;
        end
    end

    // Next-state, grant and pop-strobe logic of the wormhole lock FSM.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        last_nxt_s  = last_r;
        ack_out     = '0;
        grant_out   = '0;
        load_s      = 1'b0;
        load_idx_s  = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    grant_out[winner_s] = 1'b1;
                    if (can_load_s) begin
                        ack_out[winner_s] = 1'b1;
                        load_s            = 1'b1;
                        load_idx_s        = winner_s;
                        if (tail_in[winner_s]) begin
                            // Single-flit packet: the port stays free.
                            last_nxt_s = winner_s;
                        end else begin
                            state_nxt_s = ST_LOCKED;
                            owner_nxt_s = winner_s;
                        end
                    end else begin
                        // Stalled: pointer and state are left untouched.
                        load_s = 1'b0;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                // Only the owner is served; a request gap keeps the lock.
                grant_out[owner_r] = 1'b1;
                if (req_in[owner_r] && can_load_s) begin
                    ack_out[owner_r] = 1'b1;
                    load_s           = 1'b1;
                    load_idx_s       = owner_r;
                    if (tail_in[owner_r]) begin
                        // Re-arbitration happens on the following cycle.
                        state_nxt_s = ST_IDLE;
                        last_nxt_s  = owner_r;
                    end else begin
                        state_nxt_s = ST_LOCKED;
                    end
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, packet owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            owner_r <= '0;
            last_r  <= LAST_RST;
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Registered output stage; dataout keeps its value after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            validout <= 1'b0;
            dataout  <= '0;
        end else if (load_s) begin
            validout <= 1'b1;
            dataout  <= data_in[int'(load_idx_s)*DATA_WIDTH +: DATA_WIDTH];
        end else if (ready_in) begin
            validout <= 1'b0;
        end else begin
            validout <= validout;
        end
    end

endmodule

// File: tb/tb_router_xbar_out_port.sv
// -----------------------------------------------------------------------------
// tb_router_xbar_out_port
//
// Self-checking bench for router_xbar_out_port (NUM_IN=5, DATA_WIDTH=32).
// Part 1 applies a table of hand-computed vectors covering round-robin order,
// wormhole locking, backpressure, rotation, owner gaps and mid-packet reset.
// Part 2 drives random traffic and checks against a behavioural model: the
// arbitration rules computed with modular arithmetic plus a queue scoreboard
// that verifies every accepted flit leaves exactly once and in order.
// -----------------------------------------------------------------------------
module tb_router_xbar_out_port;

    localparam int N = 5;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_in;
    logic [N-1:0]   tail_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ack_out;
    logic [W-1:0]   dataout;
    logic           validout;
    logic           ready_in;
    logic [N-1:0]   grant_out;
    logic           locked;

    int checks = 0;
    int errors = 0;

    router_xbar_out_port #(.DATA_WIDTH(W), .NUM_IN(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .tail_in   (tail_in),
        .data_in   (data_in),
        .ack_out   (ack_out),
        .dataout   (dataout),
        .validout  (validout),
        .ready_in  (ready_in),
        .grant_out (grant_out),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] tail;
        logic         rdy;
        logic [7:0]   tag;
        logic [N-1:0] ack;
        logic [N-1:0] grant;
        logic         valid;
        logic [W-1:0] data;
        logic         locked;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic [N-1:0] rq, input logic [N-1:0] tl,
                                input logic rd, input logic [7:0] tg, input logic [N-1:0] ak,
                                input logic [N-1:0] gr, input logic vl, input logic [W-1:0] dt,
                                input logic lk);
        vec_t v;
        v.rst = r; v.req = rq; v.tail = tl; v.rdy = rd; v.tag = tg;
        v.ack = ak; v.grant = gr; v.valid = vl; v.data = dt; v.locked = lk;
        vecs.push_back(v);
    endfunction

    // Flit of input i in the table phase: tag in the top byte, input number low.
    function automatic logic [W-1:0] flit(input logic [7:0] tg, input int i);
        return {tg, 20'h00000, 4'(i)};
    endfunction

    // Behavioural model state for the random phase.
    logic         m_locked;
    int           m_owner;
    int           m_last;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [W-1:0] sb_q[$];

    task automatic model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = N - 1;
        m_valid  = 1'b0;
        m_data   = '0;
        sb_q.delete();
    endtask

    task automatic rnd_step(input int cyc);
        logic [N-1:0] exp_ack;
        logic [N-1:0] exp_grant;
        logic         can;
        logic         found;
        logic         hit;
        int           sel;
        int           idx;
        logic [W-1:0] fl;
        logic [W-1:0] popped;

        @(negedge clk);
        rst      = ($urandom_range(0, 63) == 0);
        req_in   = N'($urandom());
        tail_in  = '0;
        for (int i = 0; i < N; i++) begin
            tail_in[i] = ($urandom_range(0, 2) == 0);
            data_in[i*W +: W] = $urandom();
        end
        ready_in = ($urandom_range(0, 3) != 0);
        #1;

        check("rnd_valid", cyc, W'(validout), W'(m_valid));
        check("rnd_locked", cyc, W'(locked), W'(m_locked));
        check("rnd_data", cyc, dataout, m_data);

        exp_ack   = '0;
        exp_grant = '0;
        can       = !m_valid || ready_in;
        found     = 1'b0;
        hit       = 1'b0;
        sel       = 0;
        if (m_locked) begin
            sel = m_owner;
            exp_grant[sel] = 1'b1;
            hit = req_in[sel] && can;
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (!found && req_in[idx]) begin
                    found = 1'b1;
                    sel   = idx;
                end
            end
            if (found) begin
                exp_grant[sel] = 1'b1;
                hit = can;
            end
        end
        if (hit) exp_ack[sel] = 1'b1;

        check("rnd_ack", cyc, W'(ack_out), W'(exp_ack));
        check("rnd_grant", cyc, W'(grant_out), W'(exp_grant));

        // Downstream takes the flit at this edge: it must be the oldest accepted one.
        if (validout && ready_in) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_order[%0d] got=%h expected=<no flit pending>", cyc, dataout);
            end else begin
                popped = sb_q.pop_front();
                check("rnd_order", cyc, dataout, popped);
            end
        end

        if (rst) begin
            model_reset();
        end else if (hit) begin
            fl      = data_in[sel*W +: W];
            m_data  = fl;
            m_valid = 1'b1;
            sb_q.push_back(fl);
            if (tail_in[sel]) begin
                m_locked = 1'b0;
                m_last   = sel;
            end else begin
                m_locked = 1'b1;
                m_owner  = sel;
            end
        end else if (ready_in) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        req_in   = '0;
        tail_in  = '0;
        data_in  = '0;
        ready_in = 1'b1;

        // Round-robin between inputs 0 and 2 (single-flit packets).
        add(0, 5'b00101, 5'b00101, 1, 8'h01, 5'b00001, 5'b00001, 1, 32'h0100_0000, 0);
        add(0, 5'b00101, 5'b00101, 1, 8'h02, 5'b00100, 5'b00100, 1, 32'h0200_0002, 0);
        add(0, 5'b00101, 5'b00101, 1, 8'h03, 5'b00001, 5'b00001, 1, 32'h0300_0000, 0);
        // 3-flit packet on input 1 while input 3 keeps requesting.
        add(0, 5'b01010, 5'b01000, 1, 8'h04, 5'b00010, 5'b00010, 1, 32'h0400_0001, 1);
        add(0, 5'b01010, 5'b01000, 1, 8'h05, 5'b00010, 5'b00010, 1, 32'h0500_0001, 1);
        add(0, 5'b01010, 5'b01010, 1, 8'h06, 5'b00010, 5'b00010, 1, 32'h0600_0001, 0);
        add(0, 5'b01000, 5'b01000, 1, 8'h07, 5'b01000, 5'b01000, 1, 32'h0700_0003, 0);
        // Backpressure on input 0 for four cycles, then resume and drain.
        add(0, 5'b00001, 5'b00001, 1, 8'h08, 5'b00001, 5'b00001, 1, 32'h0800_0000, 0);
        for (int j = 0; j < 4; j++)
            add(0, 5'b00001, 5'b00001, 0, 8'(9 + j), 5'b00000, 5'b00001, 1, 32'h0800_0000, 0);
        add(0, 5'b00001, 5'b00001, 1, 8'h0D, 5'b00001, 5'b00001, 1, 32'h0D00_0000, 0);
        add(0, 5'b00000, 5'b00000, 1, 8'h0E, 5'b00000, 5'b00000, 0, 32'h0D00_0000, 0);
        // All inputs request single-flit packets; pointer sits at 0.
        for (int j = 0; j < 6; j++) begin
            w = (j + 1) % N;
            add(0, 5'b11111, 5'b11111, 1, 8'(15 + j), 5'(1 << w), 5'(1 << w), 1, flit(8'(15 + j), w), 0);
        end
        // Lock to input 4, owner gap of three cycles while input 0 waits.
        add(0, 5'b10000, 5'b00000, 1, 8'h15, 5'b10000, 5'b10000, 1, 32'h1500_0004, 1);
        for (int j = 0; j < 3; j++)
            add(0, 5'b00001, 5'b00001, 1, 8'h16, 5'b00000, 5'b10000, 0, 32'h1500_0004, 1);
        add(0, 5'b10001, 5'b10001, 1, 8'h17, 5'b10000, 5'b10000, 1, 32'h1700_0004, 0);
        add(0, 5'b00001, 5'b00001, 1, 8'h18, 5'b00001, 5'b00001, 1, 32'h1800_0000, 0);
        // Reset while locked to input 2, then input 0 wins.
        add(0, 5'b00100, 5'b00000, 1, 8'h19, 5'b00100, 5'b00100, 1, 32'h1900_0002, 1);
        add(1, 5'b00000, 5'b00000, 1, 8'h1A, 5'b00000, 5'b00100, 0, 32'h0000_0000, 0);
        add(0, 5'b00000, 5'b00000, 1, 8'h1B, 5'b00000, 5'b00000, 0, 32'h0000_0000, 0);
        add(0, 5'b11111, 5'b11111, 1, 8'h1C, 5'b00001, 5'b00001, 1, 32'h1C00_0000, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", 0, W'(validout), W'(1'b0));
        check("reset_data", 0, dataout, W'(0));
        check("reset_locked", 0, W'(locked), W'(1'b0));
        check("reset_grant", 0, W'(grant_out), W'(0));
        check("reset_ack", 0, W'(ack_out), W'(0));

        foreach (vecs[v]) begin
            @(negedge clk);
            rst      = vecs[v].rst;
            req_in   = vecs[v].req;
            tail_in  = vecs[v].tail;
            ready_in = vecs[v].rdy;
            for (int i = 0; i < N; i++) data_in[i*W +: W] = flit(vecs[v].tag, i);
            #1;
            check("vec_ack", v, W'(ack_out), W'(vecs[v].ack));
            check("vec_grant", v, W'(grant_out), W'(vecs[v].grant));
            @(posedge clk);
            #1;
            check("vec_valid", v, W'(validout), W'(vecs[v].valid));
            check("vec_data", v, dataout, vecs[v].data);
            check("vec_locked", v, W'(locked), W'(vecs[v].locked));
        end

        // Random phase starts from a clean reset so model and DUT agree.
        @(negedge clk);
        rst    = 1'b1;
        req_in = '0;
        @(posedge clk);
        model_reset();
        for (int c = 0; c < 1500; c++) rnd_step(c);

        @(negedge clk);
        rst    = 1'b0;
        req_in = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
